// File: rtl/x_bar2_pkg.sv
// Shared constants, address-field layout and route-entry type for the x_bar2 crossbar.
package x_bar2_pkg;

   localparam int unsigned XB_IN_PORTS   = 4;
   localparam int unsigned XB_OUT_PORTS  = 4;
   localparam int unsigned XB_BIT_LENGTH = 8;
   localparam int unsigned XB_PORT_W     = 2 * XB_BIT_LENGTH;
   localparam int unsigned XB_ADDR_LEN   = 5;
   localparam logic [XB_ADDR_LEN-1:0] XB_REST_ADDR = 5'h10;

   // AddressSelect layout: {rest, out_idx[1:0], in_idx[1:0]}
   localparam int unsigned REST_BIT = 4;
   localparam int unsigned OUT_LSB  = 2;
   localparam int unsigned IN_LSB   = 0;
   localparam int unsigned IDX_W    = 2;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             valid;
   } route_entry_t;

endpackage

// File: rtl/x_bar2_route_table.sv
// Route table for x_bar2: one {input index, valid} entry per output, written by AddressSelect.
module x_bar2_route_table
   import x_bar2_pkg::*;
#(
   parameter int unsigned             OUT_PORTS = XB_OUT_PORTS,
   parameter int unsigned             ADDR_LEN  = XB_ADDR_LEN,
   parameter logic [ADDR_LEN-1:0]     REST_ADDR = XB_REST_ADDR
) (
   input  logic                         Clk,
   input  logic                         Rst,
   input  logic [ADDR_LEN-1:0]          AddressSelect,
   output logic [OUT_PORTS*IDX_W-1:0]   o_route_idx,
   output logic [OUT_PORTS-1:0]         o_route_valid
);

   route_entry_t     r_route [OUT_PORTS];
   logic             w_rest;
   logic [IDX_W-1:0] w_out_sel;
   logic [IDX_W-1:0] w_in_sel;

   assign w_rest    = AddressSelect[REST_BIT] | (AddressSelect == REST_ADDR);
   assign w_out_sel = AddressSelect[OUT_LSB +: IDX_W];
   assign w_in_sel  = AddressSelect[IN_LSB +: IDX_W];

   // Reset wins over any write; otherwise the addressed entry is overwritten
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int unsigned j = 0; j < OUT_PORTS; j++) begin
            r_route[j] <= '0;
         end
      end else if (!w_rest) begin
         for (int unsigned j = 0; j < OUT_PORTS; j++) begin
            if (w_out_sel == IDX_W'(j)) begin
               r_route[j] <= '{idx: w_in_sel, valid: 1'b1};
            end
         end
      end
   end

   for (genvar j = 0; j < OUT_PORTS; j++) begin : g_out
      assign o_route_idx[j*IDX_W +: IDX_W] = r_route[j].idx;
      assign o_route_valid[j]              = r_route[j].valid;
   end

endmodule

// File: rtl/x_bar2.sv
// Registered crossbar: each output loads its routed input (or zero); optional direct
// pass-through mode is compiled in only when XBAR2_DIRECT_EN is defined.
module x_bar2
   import x_bar2_pkg::*;
#(
   parameter int unsigned         IN_PORTS   = XB_IN_PORTS,
   parameter int unsigned         OUT_PORTS  = XB_OUT_PORTS,
   parameter int unsigned         BIT_LENGTH = XB_BIT_LENGTH,
   parameter int unsigned         ADDR_LEN   = XB_ADDR_LEN,
   parameter logic [ADDR_LEN-1:0] REST_ADDR  = XB_REST_ADDR
) (
   input  logic                              Clk,
   input  logic                              Rst,
   input  logic [IN_PORTS*2*BIT_LENGTH-1:0]  flatInputPort,
   output logic [OUT_PORTS*2*BIT_LENGTH-1:0] flatOutputPort,
   input  logic [ADDR_LEN-1:0]               AddressSelect,
   input  logic                              direct
);

   localparam int unsigned PW = 2 * BIT_LENGTH;

   logic [OUT_PORTS*IDX_W-1:0] w_route_idx;
   logic [OUT_PORTS-1:0]       w_route_valid;
   logic [OUT_PORTS*PW-1:0]    w_next;
   logic [OUT_PORTS*PW-1:0]    r_out;
   logic                       w_direct;

`ifdef XBAR2_DIRECT_EN
   assign w_direct = direct;
`else
   // Port kept for interface compatibility; pass-through is not built
   logic w_unused_direct;
   assign w_unused_direct = direct;
   assign w_direct        = 1'b0;
`endif

   x_bar2_route_table #(
      .OUT_PORTS (OUT_PORTS),
      .ADDR_LEN  (ADDR_LEN),
      .REST_ADDR (REST_ADDR)
   ) u_route_table (
      .Clk           (Clk),
      .Rst           (Rst),
      .AddressSelect (AddressSelect),
      .o_route_idx   (w_route_idx),
      .o_route_valid (w_route_valid)
   );

   for (genvar j = 0; j < OUT_PORTS; j++) begin : g_mux
      logic [PW-1:0] w_routed;

      // Unconfigured or out-of-range routes yield zero rather than X
      always_comb begin
         w_routed = '0;
         for (int unsigned i = 0; i < IN_PORTS; i++) begin
            if (w_route_valid[j] && (w_route_idx[j*IDX_W +: IDX_W] == IDX_W'(i))) begin
               w_routed = flatInputPort[i*PW +: PW];
            end
         end
      end

      if (j < IN_PORTS) begin : g_dir
         assign w_next[j*PW +: PW] = w_direct ? flatInputPort[j*PW +: PW] : w_routed;
      end else begin : g_nodir
         assign w_next[j*PW +: PW] = w_routed;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_out <= '0;
      end else begin
         r_out <= w_next;
      end
   end

   assign flatOutputPort = r_out;

endmodule

// File: tb/tb_x_bar2.sv
// Directed table-driven bench for x_bar2; expectations follow XBAR2_DIRECT_EN when defined.
module tb_x_bar2;

   logic        clk;
   logic        rst;
   logic [63:0] din;
   logic [63:0] dout;
   logic [4:0]  addr;
   logic        dir;

   int total = 0;
   int bad   = 0;

`ifdef XBAR2_DIRECT_EN
   localparam bit DIR_ON = 1'b1;
`else
   localparam bit DIR_ON = 1'b0;
`endif

   typedef struct {
      logic        rst;
      logic [4:0]  addr;
      logic        dir;
      logic [63:0] din;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[$];

   x_bar2 dut (
      .Clk            (clk),
      .Rst            (rst),
      .flatInputPort  (din),
      .flatOutputPort (dout),
      .AddressSelect  (addr),
      .direct         (dir)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] pk(input logic [15:0] a0, input logic [15:0] a1,
                                      input logic [15:0] a2, input logic [15:0] a3);
      return {a3, a2, a1, a0};
   endfunction

   task automatic add(input logic r, input logic [4:0] a, input logic d,
                      input logic [63:0] i, input logic [63:0] e);
      vec_t v;
      v.rst = r; v.addr = a; v.dir = d; v.din = i; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [63:0] exp);
      for (int p = 0; p < 4; p++) begin
         chk($sformatf("%s.out%0d", tag, p), dout[p*16 +: 16], exp[p*16 +: 16]);
      end
   endtask

   logic [63:0] va, vb, ra, rb, z;
   logic [15:0] r1;
   logic [63:0] rnd;

   initial begin
      rst = 1'b1; addr = 5'h10; dir = 1'b0; din = '0;

      va = pk(16'he0f0, 16'h0021, 16'h0a60, 16'h0904);
      vb = pk(16'h0e0f, 16'h2100, 16'ha006, 16'h9040);
      ra = pk(16'h0904, 16'h0a60, 16'h0021, 16'he0f0);
      rb = pk(16'h9040, 16'ha006, 16'h2100, 16'h0e0f);
      z  = '0;

      // reversal; each write becomes visible one edge later
      add(1, 5'd3,  0, va, z);
      add(0, 5'd3,  0, va, z);
      add(0, 5'd6,  0, va, pk(16'h0904, 0, 0, 0));
      add(0, 5'd9,  0, va, pk(16'h0904, 16'h0a60, 0, 0));
      add(0, 5'd12, 0, va, pk(16'h0904, 16'h0a60, 16'h0021, 0));
      add(0, 5'h10, 0, va, ra);
      add(0, 5'h10, 0, vb, rb);
      // direct, then back to the table without rewriting
      add(0, 5'h10, 1, va, DIR_ON ? va : ra);
      add(0, 5'h10, 0, va, ra);
      // reset mid-run clears everything
      add(1, 5'h10, 0, vb, z);
      add(0, 5'h10, 0, vb, z);
      add(0, 5'h10, 0, va, z);
      // write during reset is ignored
      add(1, 5'd3,  0, va, z);
      add(0, 5'h10, 0, va, z);
      // unconfigured outputs stay zero
      add(0, 5'd3,  0, va, z);
      add(0, 5'h10, 0, va, pk(16'h0904, 0, 0, 0));
      add(0, 5'h1f, 0, vb, pk(16'h9040, 0, 0, 0));
      // overwrite and broadcast
      add(0, 5'd1,  0, va, pk(16'h0904, 0, 0, 0));
      add(0, 5'd5,  0, va, pk(16'h0021, 0, 0, 0));
      add(0, 5'h10, 0, vb, pk(16'h2100, 16'h2100, 0, 0));

      for (int k = 0; k < vecs.size(); k++) begin
         rst  = vecs[k].rst;
         addr = vecs[k].addr;
         dir  = vecs[k].dir;
         din  = vecs[k].din;
         @(posedge clk);
         #1;
         chk_all($sformatf("v%0d", k), vecs[k].exp);
      end

      // rest address held for many cycles: broadcast table must persist
      for (int c = 0; c < 30; c++) begin
         rnd  = {$urandom, $urandom};
         addr = (c % 2 == 0) ? 5'h10 : 5'h1a;
         din  = rnd;
         r1   = rnd[31:16];
         @(posedge clk);
         #1;
         chk_all($sformatf("hold%0d", c), pk(r1, r1, 0, 0));
      end

      // direct toggled with broadcast table: direct never touches the table
      din = va; dir = 1'b1; addr = 5'h10;
      @(posedge clk);
      #1;
      chk_all("dtog1", DIR_ON ? va : pk(16'h0021, 16'h0021, 0, 0));
      dir = 1'b0;
      @(posedge clk);
      #1;
      chk_all("dtog0", pk(16'h0021, 16'h0021, 0, 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
